dsp_vector_checker: RTL and testbench

- Hardware self-test driver for two-input fixed-point DSP datapaths, e.g. the SimpleDspModule adder (z = x + y).
- Holds a small table of {x, y, expected z} vectors and plays them into the DUT one per cycle.
- Compares the DUT's z output against expectation after a fixed pipeline latency and reports pass/fail plus first-failure details.
- Sits beside the DUT on-chip, driving its x/y and consuming its z: the stimulus/response end of that interface.

---
 rtl/dsp_fixed_pkg.sv | 27 ++
 rtl/dsp_expect_pipe.sv | 56 +++++
 rtl/dsp_vector_checker.sv | 163 ++++++++++++++++
 tb/tb_dsp_vector_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_fixed_pkg.sv
// Shared fixed-point types and checker state encoding for the DSP vector
// checker slice.
//   FX_WIDTH / FX_FRAC : Q3.12 sample format (4096 = 1.0)
//   fixed_t            : signed fixed-point sample
//   vec_t              : one self-test vector {x, y, expected z}
//   chk_state_t        : checker FSM states
package dsp_fixed_pkg;

  localparam int unsigned FX_WIDTH = 16;
  localparam int unsigned FX_FRAC  = 12;

  typedef logic signed [FX_WIDTH-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } chk_state_t;

endpackage

// File: rtl/dsp_expect_pipe.sv
// Expectation delay line: carries {valid, expected z, vector index} alongside
// the DUT pipeline so each expectation meets its DUT result.
//   clock, reset      : clock and synchronous active-low reset (flushes valids)
//   in_valid/exp/idx  : expectation entering the line
//   out_valid/exp/idx : expectation LATENCY cycles later (LATENCY=0: wire)
module dsp_expect_pipe
  import dsp_fixed_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned WIDTH   = FX_WIDTH,
  parameter int unsigned AW      = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_exp,
  input  logic [AW-1:0]    in_idx,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_exp,
  output logic [AW-1:0]    out_idx
);

  if (LATENCY == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_exp   = in_exp;
    assign out_idx   = in_idx;
  end else begin : g_pipe
    logic             vld   [LATENCY];
    logic [WIDTH-1:0] exp_q [LATENCY];
    logic [AW-1:0]    idx_q [LATENCY];

    always_ff @(posedge clock) begin
      if (!reset) begin
        for (int unsigned s = 0; s < LATENCY; s++) vld[s] <= 1'b0;
      end else begin
        vld[0] <= in_valid;
        for (int unsigned s = 1; s < LATENCY; s++) vld[s] <= vld[s-1];
      end
    end

    // Payload needs no reset: it is qualified by the valid bits.
    always_ff @(posedge clock) begin
      exp_q[0] <= in_exp;
      idx_q[0] <= in_idx;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        exp_q[s] <= exp_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_exp   = exp_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];
  end

endmodule

// File: rtl/dsp_vector_checker.sv
// On-chip self-test driver for a two-input DSP datapath. Plays a loaded
// vector table into the DUT one vector per cycle and compares dut_z against
// the expected value after LATENCY cycles.
//   clock, reset          : clock, synchronous active-low reset
//   ld_en/addr/x/y/z      : table write port (ignored while busy)
//   num_vec, start        : run length (clamped to DEPTH) and run request
//   dut_x, dut_y, dut_z   : stimulus to / result from the DUT
//   busy, done, pass      : run status (done sticky until next start)
//   err_count, fail_*     : mismatch count and first-mismatch details
module dsp_vector_checker
  import dsp_fixed_pkg::*;
#(
  parameter  int unsigned WIDTH   = FX_WIDTH,
  parameter  int unsigned DEPTH   = 8,
  parameter  int unsigned LATENCY = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ld_en,
  input  logic [AW-1:0]           ld_addr,
  input  logic signed [WIDTH-1:0] ld_x,
  input  logic signed [WIDTH-1:0] ld_y,
  input  logic signed [WIDTH-1:0] ld_z,
  input  logic [AW:0]             num_vec,
  input  logic                    start,
  output logic signed [WIDTH-1:0] dut_x,
  output logic signed [WIDTH-1:0] dut_y,
  input  logic signed [WIDTH-1:0] dut_z,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [AW:0]             err_count,
  output logic [AW-1:0]           fail_idx,
  output logic signed [WIDTH-1:0] fail_got,
  output logic signed [WIDTH-1:0] fail_exp
);

  chk_state_t       state;
  logic [WIDTH-1:0] tab_x [DEPTH];
  logic [WIDTH-1:0] tab_y [DEPTH];
  logic [WIDTH-1:0] tab_z [DEPTH];
  logic [AW-1:0]    iss_idx;
  logic [AW-1:0]    last_idx;
  logic [AW:0]      n_clamp;

  // Stage 0 registers the expectation on the same edge as dut_x/dut_y; the
  // delay line then adds LATENCY cycles to meet dut_z.
  logic             s0_valid;
  logic [WIDTH-1:0] s0_exp;
  logic [AW-1:0]    s0_idx;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_exp;
  logic [AW-1:0]    cmp_idx;
  logic             mis;
  logic [AW:0]      err_next;

  dsp_expect_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (WIDTH),
    .AW      (AW)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (s0_valid),
    .in_exp    (s0_exp),
    .in_idx    (s0_idx),
    .out_valid (cmp_valid),
    .out_exp   (cmp_exp),
    .out_idx   (cmp_idx)
  );

  always_comb begin
    n_clamp  = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    mis      = cmp_valid && (dut_z != cmp_exp);
    err_next = err_count + (AW+1)'(mis);
  end

  assign busy = (state == S_RUN) || (state == S_DRAIN);

  // Table is deliberately not reset so vectors survive an aborted run.
  always_ff @(posedge clock) begin
    if (ld_en && (state == S_IDLE || state == S_DONE)) begin
      tab_x[ld_addr] <= ld_x;
      tab_y[ld_addr] <= ld_y;
      tab_z[ld_addr] <= ld_z;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      dut_x     <= '0;
      dut_y     <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
      fail_got  <= '0;
      fail_exp  <= '0;
      iss_idx   <= '0;
      last_idx  <= '0;
      s0_valid  <= 1'b0;
      s0_exp    <= '0;
      s0_idx    <= '0;
    end else begin
      dut_x    <= '0;
      dut_y    <= '0;
      s0_valid <= 1'b0;

      if (mis) begin
        err_count <= err_next;
        if (err_count == '0) begin
          fail_idx <= cmp_idx;
          fail_got <= dut_z;
          fail_exp <= cmp_exp;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count <= '0;
            fail_idx  <= '0;
            fail_got  <= '0;
            fail_exp  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            iss_idx   <= '0;
            if (n_clamp == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state    <= S_RUN;
              last_idx <= AW'(n_clamp - (AW+1)'(1));
            end
          end
        end
        S_RUN: begin
          dut_x    <= tab_x[iss_idx];
          dut_y    <= tab_y[iss_idx];
          s0_valid <= 1'b1;
          s0_exp   <= tab_z[iss_idx];
          s0_idx   <= iss_idx;
          if (iss_idx == last_idx) state <= S_DRAIN;
          else iss_idx <= iss_idx + AW'(1);
        end
        S_DRAIN: begin
          // Completion coincides with the last compare, so status uses
          // err_next to include it.
          if (cmp_valid && cmp_idx == last_idx) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_vector_checker.sv
// Self-checking bench: two checker instances (LATENCY=1 with a registered
// adder, LATENCY=0 with a combinational adder) share stimulus and are
// compared against a table-level reference model every cycle.
module tb_dsp_vector_checker;
  import dsp_fixed_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  fixed_t        ld_x = '0, ld_y = '0, ld_z = '0;
  logic [AW:0]   num_vec = '0;
  logic          start = 1'b0;

  fixed_t        x1, y1, z1, fgot1, fexp1;
  fixed_t        x0, y0, z0, fgot0, fexp0;
  logic          busy1, done1, pass1, busy0, done0, pass0;
  logic [AW:0]   err1, err0;
  logic [AW-1:0] fidx1, fidx0;

  int   checks = 0;
  int   errors = 0;
  vec_t mtab [DEPTH];

  always #5 clock = ~clock;

  always_ff @(posedge clock) z1 <= x1 + y1;
  assign z0 = x0 + y0;

  dsp_vector_checker #(.WIDTH(16), .DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_x(ld_x), .ld_y(ld_y), .ld_z(ld_z), .num_vec(num_vec), .start(start),
    .dut_x(x1), .dut_y(y1), .dut_z(z1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_idx(fidx1), .fail_got(fgot1),
    .fail_exp(fexp1));

  dsp_vector_checker #(.WIDTH(16), .DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clock(clock), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_x(ld_x), .ld_y(ld_y), .ld_z(ld_z), .num_vec(num_vec), .start(start),
    .dut_x(x0), .dut_y(y0), .dut_z(z0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_idx(fidx0), .fail_got(fgot0),
    .fail_exp(fexp0));

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int addr, input fixed_t x, input fixed_t y,
                      input fixed_t z);
    ld_en = 1'b1; ld_addr = AW'(addr); ld_x = x; ld_y = y; ld_z = z;
    tick();
    ld_en = 1'b0;
    mtab[addr] = '{x: x, y: y, z: z};
  endtask

  task automatic check_all_zero(input string name);
    check({name, " L0 dut_x"}, x0, 0);    check({name, " L1 dut_x"}, x1, 0);
    check({name, " L0 dut_y"}, y0, 0);    check({name, " L1 dut_y"}, y1, 0);
    check({name, " L0 busy"}, busy0, 0);  check({name, " L1 busy"}, busy1, 0);
    check({name, " L0 done"}, done0, 0);  check({name, " L1 done"}, done1, 0);
    check({name, " L0 pass"}, pass0, 0);  check({name, " L1 pass"}, pass1, 0);
    check({name, " L0 err"}, err0, 0);    check({name, " L1 err"}, err1, 0);
    check({name, " L0 fidx"}, fidx0, 0);  check({name, " L1 fidx"}, fidx1, 0);
    check({name, " L0 fgot"}, fgot0, 0);  check({name, " L1 fgot"}, fgot1, 0);
    check({name, " L0 fexp"}, fexp0, 0);  check({name, " L1 fexp"}, fexp1, 0);
  endtask

  // Starts a run and checks both instances cycle by cycle. poke drives
  // start and a table write to entry 0 while the run is in progress.
  task automatic run_check(input string name, input int nv, input bit poke);
    int     n, exp_err, exp_fidx, lat;
    fixed_t s, exp_fgot, exp_fexp, ex, ey;
    bit     exp_done, exp_busy;
    n = (nv > DEPTH) ? DEPTH : nv;
    exp_err = 0; exp_fidx = 0; exp_fgot = '0; exp_fexp = '0;
    for (int i = 0; i < n; i++) begin
      s = mtab[i].x + mtab[i].y;
      if (s != mtab[i].z) begin
        if (exp_err == 0) begin
          exp_fidx = i; exp_fgot = s; exp_fexp = mtab[i].z;
        end
        exp_err++;
      end
    end
    num_vec = (AW+1)'(nv);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= n + 2; c++) begin
      if (c > 0) tick();
      ex = (c >= 1 && c <= n) ? mtab[c-1].x : fixed_t'(0);
      ey = (c >= 1 && c <= n) ? mtab[c-1].y : fixed_t'(0);
      for (int d = 0; d < 2; d++) begin
        lat = d;
        exp_done = (n == 0) ? 1'b1 : (c >= n + 1 + lat);
        exp_busy = (n != 0) && (c <= n + lat);
        check($sformatf("%s L%0d dut_x c%0d", name, lat, c), d ? x1 : x0, ex);
        check($sformatf("%s L%0d dut_y c%0d", name, lat, c), d ? y1 : y0, ey);
        check($sformatf("%s L%0d done c%0d", name, lat, c),
              d ? done1 : done0, exp_done);
        check($sformatf("%s L%0d busy c%0d", name, lat, c),
              d ? busy1 : busy0, exp_busy);
      end
      if (poke && c == 1) begin
        start = 1'b1; ld_en = 1'b1; ld_addr = '0;
        ld_x = '0; ld_y = '0; ld_z = '0;
      end else if (poke && c == 2) begin
        start = 1'b0; ld_en = 1'b0;
      end
    end
    check({name, " L0 pass"}, pass0, exp_err == 0);
    check({name, " L1 pass"}, pass1, exp_err == 0);
    check({name, " L0 err_count"}, err0, exp_err);
    check({name, " L1 err_count"}, err1, exp_err);
    check({name, " L0 fail_idx"}, fidx0, exp_fidx);
    check({name, " L1 fail_idx"}, fidx1, exp_fidx);
    check({name, " L0 fail_got"}, fgot0, exp_fgot);
    check({name, " L1 fail_got"}, fgot1, exp_fgot);
    check({name, " L0 fail_exp"}, fexp0, exp_fexp);
    check({name, " L1 fail_exp"}, fexp1, exp_fexp);
  endtask

  initial begin
    fixed_t rx, ry, rz;

    tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Nominal run.
    load(0, -16'sd4506, -16'sd4506, -16'sd9012);
    load(1, -16'sd1638, -16'sd1638, -16'sd3276);
    load(2,  16'sd1638,  16'sd1638,  16'sd3276);
    load(3,  16'sd4506,  16'sd4506,  16'sd9012);
    run_check("nominal", 4, 1'b0);
    check("nominal L1 pass const", pass1, 1);

    // Fault injection on entry 2.
    load(2, 16'sd1638, 16'sd1638, 16'sd3277);
    run_check("fault", 4, 1'b0);
    check("fault L1 fail_got const", fgot1, 3276);
    check("fault L1 fail_exp const", fexp1, 3277);
    load(2, 16'sd1638, 16'sd1638, 16'sd3276);

    run_check("empty", 0, 1'b0);

    // Reset mid-run, then a fresh run on the retained table.
    num_vec = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_all_zero("midreset");
    reset = 1'b1;
    tick();
    run_check("after_reset", 4, 1'b0);

    // start and ld_en during RUN are ignored.
    run_check("poke", 4, 1'b1);
    run_check("rerun", 4, 1'b0);

    // Clamp: 15 requested, 8 issued.
    for (int i = 0; i < 8; i++)
      load(i, fixed_t'(i * 1000 - 3000), fixed_t'(512 * i), fixed_t'(i * 1512 - 3000));
    run_check("clamp", 15, 1'b0);

    // Randomized tables with sparse corrupted expectations.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) begin
        rx = fixed_t'($urandom);
        ry = fixed_t'($urandom);
        rz = rx + ry;
        if ($urandom_range(0, 3) == 0) rz = rz ^ fixed_t'($urandom_range(1, 65535));
        load(i, rx, ry, rz);
      end
      run_check($sformatf("rand%0d", it), int'($urandom_range(0, 15)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
